// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single fixed-latency memory port.
// Define FIXED_PRIO_EN to make master 0 win simultaneous requests; otherwise round-robin.
module mem_port_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_op,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_op,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              mem_enable,
    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t     state;
    logic [3:0] cnt;
    logic       winner;
    req_t       win_req;

`ifdef FIXED_PRIO_EN
    assign winner = ~m0_req;
`else
    logic last_grant;
    // Simultaneous requests go to whichever master did not win last time.
    assign winner = (m0_req && m1_req) ? ~last_grant : m1_req;
`endif

    assign win_req = winner ? req_t'{m1_op, m1_addr, m1_wdata}
                            : req_t'{m0_op, m0_addr, m0_wdata};
    assign busy    = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_enable <= 1'b0;
            mem_op     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            grant_id   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
`ifndef FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        mem_op     <= win_req.op;
                        mem_addr   <= win_req.addr;
                        mem_wdata  <= win_req.wdata;
                        mem_enable <= 1'b1;
                        grant_id   <= winner;
                        cnt        <= LAT_M1;
`ifndef FIXED_PRIO_EN
                        last_grant <= winner;
`endif
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        mem_enable <= 1'b0;
                        if (!mem_op) begin
                            if (grant_id) m1_rdata <= mem_rdata;
                            else          m0_rdata <= mem_rdata;
                        end
                        if (grant_id) m1_ack <= 1'b1;
                        else          m0_ack <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
